// File: rtl/credit_flowcontrol.sv
// credit_flowcontrol: per-output saturating credit counters gating arbiter ready (optional CREDIT_ERR_EN: sticky err_out/err_port)
module credit_flowcontrol #(
  parameter int NPORTS = 3,
  parameter int CREDITS = 4,
  parameter int CW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NPORTS-1:0]    port_sel,
  input  logic [NPORTS-1:0]    flit_sent,
  input  logic [NPORTS-1:0]    credit_in,
  output logic [NPORTS-1:0]    ready_out,
`ifdef CREDIT_ERR_EN
  output logic                 err_out,
  output logic [NPORTS-1:0]    err_port,
`endif
  output logic [NPORTS*CW-1:0] credit_cnt
);
  localparam logic [CW-1:0] FULL = CW'(CREDITS);
  if ((1 << CW) <= CREDITS) begin : g_cw_chk
    $error("CW too narrow for CREDITS");
  end
  logic [NPORTS-1:0] empty, full;
  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    logic [CW-1:0] cnt;
    logic dec, inc;
    assign empty[i] = cnt == '0;
    assign full[i] = cnt == FULL;
    assign dec = flit_sent[i] & ~empty[i];
    assign inc = credit_in[i] & ~full[i];
    assign credit_cnt[i*CW +: CW] = cnt;
    always_ff @(posedge clk)
      cnt <= rst ? FULL : (inc & ~dec) ? cnt + 1'b1 : (dec & ~inc) ? cnt - 1'b1 : cnt;
  end
  always_comb ready_out = rst ? '0 : port_sel & ~empty;
`ifdef CREDIT_ERR_EN
  always_ff @(posedge clk)
    err_port <= rst ? '0 : err_port | (flit_sent & empty) | (credit_in & full);
  assign err_out = |err_port;
`endif
endmodule

// File: tb/tb_credit_flowcontrol.sv
// tb_credit_flowcontrol: directed plus random checks against an arithmetic credit model
module tb_credit_flowcontrol;
  localparam int N = 3;
  localparam int CR = 4;
  localparam int W = 3;
  logic clk = 0, rst = 1;
  logic [N-1:0] port_sel = 0, flit_sent = 0, credit_in = 0, ready_out;
  logic [N*W-1:0] credit_cnt;
`ifdef CREDIT_ERR_EN
  logic err_out;
  logic [N-1:0] err_port;
  int em [N];
`endif
  int mdl [N];
  int tests = 0, fails = 0;

  credit_flowcontrol #(.NPORTS(N), .CREDITS(CR), .CW(W)) dut (
    .clk(clk), .rst(rst), .port_sel(port_sel), .flit_sent(flit_sent),
    .credit_in(credit_in), .ready_out(ready_out),
`ifdef CREDIT_ERR_EN
    .err_out(err_out), .err_port(err_port),
`endif
    .credit_cnt(credit_cnt));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [N-1:0] s, input logic [N-1:0] f, input logic [N-1:0] c, input logic r);
    logic [N-1:0] er;
    logic [N*W-1:0] ec;
    port_sel = s; flit_sent = f; credit_in = c; rst = r;
    #1;
    for (int i = 0; i < N; i++) er[i] = !r && s[i] && mdl[i] != 0;
    chk("ready_out", 32'(ready_out), 32'(er));
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
`ifdef CREDIT_ERR_EN
      em[i] = r ? 0 : (em[i] | int'((f[i] && mdl[i] == 0) || (c[i] && mdl[i] == CR)));
`endif
      if (r) mdl[i] = CR;
      else mdl[i] = mdl[i] - int'(f[i] && mdl[i] > 0) + int'(c[i] && mdl[i] < CR);
      ec[i*W +: W] = W'(mdl[i]);
    end
    #1;
    chk("credit_cnt", 32'(credit_cnt), 32'(ec));
`ifdef CREDIT_ERR_EN
    for (int i = 0; i < N; i++) er[i] = em[i] != 0;
    chk("err_port", 32'(err_port), 32'(er));
    chk("err_out", 32'(err_out), 32'(|er));
`endif
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < N; i++) mdl[i] = CR;
`ifdef CREDIT_ERR_EN
    for (int i = 0; i < N; i++) em[i] = 0;
`endif
    @(negedge clk);
    step(3'b111, 3'b111, 3'b000, 1);
    step(3'b000, 3'b000, 3'b000, 1);
    step(3'b000, 3'b000, 3'b000, 0);
    step(3'b010, 3'b000, 3'b000, 0);
    repeat (5) step(3'b001, 3'b001, 3'b000, 0);
    step(3'b001, 3'b000, 3'b001, 0);
    step(3'b001, 3'b000, 3'b000, 0);
    repeat (3) step(3'b001, 3'b001, 3'b001, 0);
    step(3'b010, 3'b000, 3'b010, 0);
    repeat (2) step(3'b100, 3'b100, 3'b000, 0);
    step(3'b111, 3'b100, 3'b000, 1);
    step(3'b111, 3'b000, 3'b000, 0);
    step(3'b000, 3'b010, 3'b000, 0);
    step(3'b111, 3'b101, 3'b010, 0);
    step(3'b111, 3'b000, 3'b000, 0);
    repeat (300)
      step(N'($urandom), N'($urandom), N'($urandom), $urandom_range(0, 40) == 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
